// File: rtl/div_iter.sv
// rtl/div_iter.sv - iterative radix-2 restoring divider, signed/unsigned, with cancel
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             div_clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             div_cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   ymag;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] x_orig;
    logic             x_sign;
    logic             y_sign;
    logic             div_zero;
    logic [WIDTH+1:0] shifted;
    logic             keep;

    // Shift the next dividend bit into the partial remainder and trial-compare against |y|.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        keep    = (shifted >= {1'b0, ymag});
    end

    always_ff @(posedge div_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s         <= '0;
            r         <= '0;
            count     <= '0;
            rem       <= '0;
            ymag      <= '0;
            dvd       <= '0;
            quo       <= '0;
            x_orig    <= '0;
            x_sign    <= 1'b0;
            y_sign    <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_sign   <= div_signed & x[WIDTH-1];
                        y_sign   <= div_signed & y[WIDTH-1];
                        // W-bit negation keeps 0x80000000 as its own magnitude.
                        dvd      <= (div_signed & x[WIDTH-1]) ? -x : x;
                        ymag     <= {1'b0, ((div_signed & y[WIDTH-1]) ? -y : y)};
                        x_orig   <= x;
                        div_zero <= (y == '0);
                        rem      <= '0;
                        quo      <= '0;
                        count    <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (div_cancel) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        rem   <= keep ? (WIDTH+1)'(shifted - {1'b0, ymag}) : shifted[WIDTH:0];
                        quo   <= {quo[WIDTH-2:0], keep};
                        dvd   <= dvd << 1;
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (div_cancel) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        if (div_zero) begin
                            s <= '1;
                            r <= x_orig;
                        end else begin
                            s <= (x_sign ^ y_sign) ? -quo : quo;
                            r <= x_sign ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (div_cancel || out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
